// File: rtl/usb_pkg.sv
// Shared definitions for the USB token receive path: PID codes, CRC5 constants,
// decoder state encoding and the serial CRC5 update.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;

    localparam logic [1:0] PID_CLASS_TOKEN = 2'b01;

    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_BODY,
        ST_WAIT_EOP,
        ST_IGNORE
    } rx_state_t;

    // One bit of x^5+x^2+1, shifting toward q[4].
    function automatic logic [4:0] crc5_next(input logic [4:0] q, input logic d);
        return {q[3], q[2], q[1] ^ q[4] ^ d, q[0], q[4] ^ d};
    endfunction

    // SOF only counts as a token when the frame-number path is enabled.
    function automatic logic pid_is_token(input logic [3:0] pid, input logic sof_en);
        logic r;
        case (pid)
            PID_OUT, PID_IN, PID_SETUP: r = 1'b1;
            PID_SOF:                    r = sof_en;
            default:                    r = 1'b0;
        endcase
        return r && (pid[1:0] == PID_CLASS_TOKEN);
    endfunction

endpackage

// File: rtl/usb_token_rx_if.sv
// Bit-stream input and decoded-token output bundle between the PHY front end,
// the token decoder and the protocol engine.
interface usb_token_rx_if;

    logic       pkt_start;
    logic       bit_valid;
    logic       bit_data;
    logic       pkt_eop;
    logic [6:0] dev_addr;

    logic       tok_valid;
    logic [3:0] tok_pid;
    logic [6:0] tok_addr;
    logic [3:0] tok_endp;
    logic       tok_match;
    logic       pid_err;
    logic       crc_err;
    logic       len_err;

    modport master (
        output pkt_start, bit_valid, bit_data, pkt_eop, dev_addr,
        input  tok_valid, tok_pid, tok_addr, tok_endp, tok_match,
               pid_err, crc_err, len_err
    );

    modport slave (
        input  pkt_start, bit_valid, bit_data, pkt_eop, dev_addr,
        output tok_valid, tok_pid, tok_addr, tok_endp, tok_match,
               pid_err, crc_err, len_err
    );

endinterface

// File: rtl/usb_crc5_ser.sv
// Serial CRC5 LFSR; init has priority over en so a restart never folds in a stray bit.
module usb_crc5_ser
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic       d,
    output logic [4:0] q
);

    logic [4:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= CRC5_INIT;
        end else if (init) begin
            r_q <= CRC5_INIT;
        end else if (en) begin
            r_q <= crc5_next(r_q, d);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/usb_token_rx.sv
// USB token packet decoder: shifts PID and address/endpoint bits LSB first, checks the
// PID complement and CRC5 residual at EOP, and emits one registered strobe per packet.
module usb_token_rx
    import usb_pkg::*;
#(
    parameter bit SOF_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    usb_token_rx_if.slave  bus
);

    rx_state_t   r_state, w_state_bit, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_ovl, w_ovl_bit, w_ovl_nxt;
    logic [7:0]  r_pid, w_pid_sh;
    logic [10:0] r_body, w_body_sh;
    logic [4:0]  w_crc_q, w_crc_eval;
    logic        w_pid_bit, w_body_bit, w_eop_act;
    logic        w_tok_set, w_pid_err_set, w_crc_err_set, w_len_err_set;

    logic        r_tok_valid, r_tok_match, r_pid_err, r_crc_err, r_len_err;
    logic [3:0]  r_tok_pid, r_tok_endp;
    logic [6:0]  r_tok_addr;

    // A bit arriving with pkt_start belongs to no packet and is dropped.
    assign w_pid_bit  = bus.bit_valid && !bus.pkt_start && (r_state == ST_PID);
    assign w_body_bit = bus.bit_valid && !bus.pkt_start && (r_state == ST_BODY);
    assign w_eop_act  = bus.pkt_eop && !bus.pkt_start && (r_state != ST_IDLE);

    // Shifted views include the current bit so an EOP in the same cycle sees it.
    assign w_pid_sh  = w_pid_bit ? {bus.bit_data, r_pid[7:1]} : r_pid;
    assign w_body_sh = (w_body_bit && (r_cnt < 4'd11)) ? {bus.bit_data, r_body[10:1]} : r_body;

    usb_crc5_ser u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (bus.pkt_start),
        .en   (w_body_bit),
        .d    (bus.bit_data),
        .q    (w_crc_q)
    );

    assign w_crc_eval = w_body_bit ? crc5_next(w_crc_q, bus.bit_data) : w_crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ovl   <= 1'b0;
            r_pid   <= 8'd0;
            r_body  <= 11'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovl   <= w_ovl_nxt;
            r_pid   <= w_pid_sh;
            r_body  <= w_body_sh;
        end
    end

    // Bit processing first (w_state_bit), then EOP, then pkt_start overriding both.
    always_comb begin
        w_state_bit = r_state;
        w_ovl_bit   = r_ovl;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_PID: begin
                if (w_pid_bit) begin
                    if (r_cnt == 4'd7) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_bit = pid_is_token(w_pid_sh[3:0], SOF_EN) ? ST_BODY : ST_IGNORE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_BODY: begin
                if (w_body_bit) begin
                    if (r_cnt == 4'd15) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_bit = ST_WAIT_EOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (bus.bit_valid && !bus.pkt_start) begin
                    w_state_bit = ST_IGNORE;
                    w_ovl_bit   = 1'b1;
                end
            end
            default: ;
        endcase

        w_state_nxt = w_state_bit;
        w_ovl_nxt   = w_ovl_bit;
        if (w_eop_act) begin
            w_state_nxt = ST_IDLE;
            w_ovl_nxt   = 1'b0;
            w_cnt_nxt   = 4'd0;
        end
        if (bus.pkt_start) begin
            w_state_nxt = ST_PID;
            w_ovl_nxt   = 1'b0;
            w_cnt_nxt   = 4'd0;
        end
    end

    always_comb begin
        w_tok_set     = 1'b0;
        w_pid_err_set = 1'b0;
        w_crc_err_set = 1'b0;
        w_len_err_set = 1'b0;
        if (w_eop_act) begin
            case (w_state_bit)
                ST_PID, ST_BODY: w_len_err_set = 1'b1;
                ST_WAIT_EOP: begin
                    if (w_pid_sh[7:4] != ~w_pid_sh[3:0]) begin
                        w_pid_err_set = 1'b1;
                    end else if (w_crc_eval != CRC5_RESIDUAL) begin
                        w_crc_err_set = 1'b1;
                    end else begin
                        w_tok_set = 1'b1;
                    end
                end
                ST_IGNORE: w_len_err_set = w_ovl_bit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_valid <= 1'b0;
            r_pid_err   <= 1'b0;
            r_crc_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_tok_pid   <= 4'd0;
            r_tok_addr  <= 7'd0;
            r_tok_endp  <= 4'd0;
            r_tok_match <= 1'b0;
        end else begin
            r_tok_valid <= w_tok_set;
            r_pid_err   <= w_pid_err_set;
            r_crc_err   <= w_crc_err_set;
            r_len_err   <= w_len_err_set;
            if (w_tok_set) begin
                r_tok_pid   <= w_pid_sh[3:0];
                r_tok_addr  <= w_body_sh[6:0];
                r_tok_endp  <= w_body_sh[10:7];
                r_tok_match <= (w_pid_sh[3:0] != PID_SOF) && (w_body_sh[6:0] == bus.dev_addr);
            end
        end
    end

    assign bus.tok_valid = r_tok_valid;
    assign bus.tok_pid   = r_tok_pid;
    assign bus.tok_addr  = r_tok_addr;
    assign bus.tok_endp  = r_tok_endp;
    assign bus.tok_match = r_tok_match;
    assign bus.pid_err   = r_pid_err;
    assign bus.crc_err   = r_crc_err;
    assign bus.len_err   = r_len_err;

endmodule
